mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_if.sv | 34 +++
 rtl/mc_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle controller (master) and its datapath (slave).
// Instruction fields and status flags flow in; datapath strobes and mux selects flow out.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] regdst;
    logic [1:0] wb_sel;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_we, pc_src, iord, mem_rd, mem_wr, ir_we, reg_we,
               regdst, wb_sel, alusrca, alusrcb, alu_op, state, illegal
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_we, pc_src, iord, mem_rd, mem_wr, ir_we, reg_we,
               regdst, wb_sel, alusrca, alusrcb, alu_op, state, illegal
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-style controller FSM (lw/sw/R-type/beq/j/addi).
// Optional jal support is enabled by defining MC_CTRL_JAL_EN.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        ST_IF    = 4'd0,
        ST_ID    = 4'd1,
        ST_MADDR = 4'd2,
        ST_MRD   = 4'd3,
        ST_WBLW  = 4'd4,
        ST_MWR   = 4'd5,
        ST_EXR   = 4'd6,
        ST_WBR   = 4'd7,
        ST_BEQ   = 4'd8,
        ST_J     = 4'd9,
        ST_EXI   = 4'd10,
`ifdef MC_CTRL_JAL_EN
        ST_WBI   = 4'd11,
        ST_JAL   = 4'd12
`else
        ST_WBI   = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     cur;
    state_t     nxt;

    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] regdst;
    logic [1:0] wb_sel;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alu_op;
    logic       illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= ST_IF;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt     = ST_IF;
        pc_we   = 1'b0;
        pc_src  = 2'b00;
        iord    = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ir_we   = 1'b0;
        reg_we  = 1'b0;
        regdst  = 2'b00;
        wb_sel  = 2'b00;
        alusrca = 1'b0;
        alusrcb = 2'b00;
        alu_op  = 3'b000;
        illegal = 1'b0;

        case (cur)
            ST_IF: begin
                mem_rd  = 1'b1;
                alusrcb = 2'b01;
                alu_op  = ALU_ADD;
                pc_we   = bus.mem_ready;
                ir_we   = bus.mem_ready;
                nxt     = bus.mem_ready ? ST_ID : ST_IF;
            end
            // Branch target (PC + imm<<2) is precomputed here for the beq state.
            ST_ID: begin
                alusrcb = 2'b11;
                alu_op  = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: nxt = ST_MADDR;
                    OP_R:         nxt = ST_EXR;
                    OP_BEQ:       nxt = ST_BEQ;
                    OP_J:         nxt = ST_J;
                    OP_ADDI:      nxt = ST_EXI;
`ifdef MC_CTRL_JAL_EN
                    OP_JAL:       nxt = ST_JAL;
`endif
                    default: begin
                        illegal = 1'b1;
                        nxt     = ST_IF;
                    end
                endcase
            end
            ST_MADDR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alu_op  = ALU_ADD;
                nxt     = (bus.op == OP_SW) ? ST_MWR : ST_MRD;
            end
            ST_MRD: begin
                iord   = 1'b1;
                mem_rd = 1'b1;
                nxt    = bus.mem_ready ? ST_WBLW : ST_MRD;
            end
            ST_WBLW: begin
                reg_we = 1'b1;
                wb_sel = 2'b01;
            end
            ST_MWR: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
                nxt    = bus.mem_ready ? ST_IF : ST_MWR;
            end
            // Unknown funct aborts back to fetch so the write-back state never runs.
            ST_EXR: begin
                alusrca = 1'b1;
                nxt     = ST_WBR;
                case (bus.funct)
                    6'b100000: alu_op = ALU_ADD;
                    6'b100010: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b101010: alu_op = ALU_SLT;
                    default: begin
                        alu_op  = ALU_ADD;
                        illegal = 1'b1;
                        nxt     = ST_IF;
                    end
                endcase
            end
            ST_WBR: begin
                reg_we = 1'b1;
                regdst = 2'b01;
            end
            ST_BEQ: begin
                alusrca = 1'b1;
                alu_op  = ALU_SUB;
                pc_src  = 2'b01;
                pc_we   = bus.zero;
            end
            ST_J: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
            ST_EXI: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alu_op  = ALU_ADD;
                nxt     = ST_WBI;
            end
            ST_WBI: begin
                reg_we = 1'b1;
            end
`ifdef MC_CTRL_JAL_EN
            ST_JAL: begin
                reg_we = 1'b1;
                regdst = 2'b10;
                wb_sel = 2'b10;
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
`endif
            default: nxt = ST_IF;
        endcase

        // Reset holds the fetch muxes but suppresses every strobe and enable.
        if (rst) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            reg_we  = 1'b0;
            mem_rd  = 1'b0;
            mem_wr  = 1'b0;
            illegal = 1'b0;
        end
    end

    assign bus.pc_we   = pc_we;
    assign bus.pc_src  = pc_src;
    assign bus.iord    = iord;
    assign bus.mem_rd  = mem_rd;
    assign bus.mem_wr  = mem_wr;
    assign bus.ir_we   = ir_we;
    assign bus.reg_we  = reg_we;
    assign bus.regdst  = regdst;
    assign bus.wb_sel  = wb_sel;
    assign bus.alusrca = alusrca;
    assign bus.alusrcb = alusrcb;
    assign bus.alu_op  = alu_op;
    assign bus.state   = cur;
    assign bus.illegal = illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: per-instruction expected output records are queued
// when an instruction is driven and popped/compared once per cycle.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] regdst;
        logic [1:0] wb_sel;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alu_op;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t  exp;
        obs_t  mask;
        string name;
    } sb_t;

    typedef struct {
        string            name;
        logic [5:0]       op;
        logic [5:0]       funct;
        logic             zero;
        int               len;
        logic [4:0][3:0]  seq;
        logic [2:0]       exrAlu;
        logic             ill;
    } vec_t;

    sb_t  sbQ[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    obs_t allBits;

    // Expected outputs of each state, taken straight from the state table.
    function automatic obs_t expectFor(input logic [3:0] s, input logic mr, input logic z,
                                       input logic [2:0] aop, input logic ill);
        obs_t e;
        e = '0;
        e.state = s;
        case (s)
            4'd0:  begin e.mem_rd = 1; e.alusrcb = 2'b01; e.alu_op = 3'b010; e.pc_we = mr; e.ir_we = mr; end
            4'd1:  begin e.alusrcb = 2'b11; e.alu_op = 3'b010; e.illegal = ill; end
            4'd2:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.alu_op = 3'b010; end
            4'd3:  begin e.iord = 1; e.mem_rd = 1; end
            4'd4:  begin e.reg_we = 1; e.wb_sel = 2'b01; end
            4'd5:  begin e.iord = 1; e.mem_wr = 1; end
            4'd6:  begin e.alusrca = 1; e.alu_op = aop; e.illegal = ill; end
            4'd7:  begin e.reg_we = 1; e.regdst = 2'b01; end
            4'd8:  begin e.alusrca = 1; e.alu_op = 3'b110; e.pc_src = 2'b01; e.pc_we = z; end
            4'd9:  begin e.pc_src = 2'b10; e.pc_we = 1; end
            4'd10: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alu_op = 3'b010; end
            4'd11: begin e.reg_we = 1; end
            4'd12: begin e.reg_we = 1; e.regdst = 2'b10; e.wb_sel = 2'b10; e.pc_src = 2'b10; e.pc_we = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic obs_t resetExp();
        obs_t e;
        e = expectFor(4'd0, 1'b1, 1'b0, 3'b000, 1'b0);
        e.pc_we  = 0;
        e.ir_we  = 0;
        e.mem_rd = 0;
        return e;
    endfunction

    function automatic obs_t sampleDut();
        obs_t g;
        g.state   = bus.state;
        g.pc_we   = bus.pc_we;
        g.pc_src  = bus.pc_src;
        g.iord    = bus.iord;
        g.mem_rd  = bus.mem_rd;
        g.mem_wr  = bus.mem_wr;
        g.ir_we   = bus.ir_we;
        g.reg_we  = bus.reg_we;
        g.regdst  = bus.regdst;
        g.wb_sel  = bus.wb_sel;
        g.alusrca = bus.alusrca;
        g.alusrcb = bus.alusrcb;
        g.alu_op  = bus.alu_op;
        g.illegal = bus.illegal;
        return g;
    endfunction

    function automatic vec_t mkVec(input string nm, input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input int len, input logic [19:0] seq,
                                   input logic [2:0] aop, input logic ill);
        vec_t v;
        v.name   = nm;
        v.op     = op;
        v.funct  = fn;
        v.zero   = z;
        v.len    = len;
        v.seq    = seq;
        v.exrAlu = aop;
        v.ill    = ill;
        return v;
    endfunction

    task automatic checkOutput();
        sb_t  t;
        obs_t got;
        checks++;
        if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty got no entry exp one entry");
            return;
        end
        t   = sbQ.pop_front();
        got = sampleDut();
        if (((got ^ t.exp) & t.mask) !== 23'h0) begin
            errors++;
            $display("[TB] FAIL %s got %h exp %h (mask %h)", t.name, got, t.exp, t.mask);
        end
    endtask

    // Queue one expectation, sample it #1 after the falling edge, then advance a cycle.
    task automatic expectCycle(input obs_t e, input obs_t m, input string nm);
        sbQ.push_back('{exp: e, mask: m, name: nm});
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        obs_t m;
        logic ill;
        bus.op        = v.op;
        bus.funct     = v.funct;
        bus.zero      = v.zero;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < v.len; i++) begin
            ill = v.ill && (i == v.len - 1);
            m   = allBits;
            if (ill && v.seq[i] == 4'd6) m.alu_op = 3'b000;
            sbQ.push_back('{exp: expectFor(v.seq[i], 1'b1, v.zero, v.exrAlu, ill),
                            mask: m, name: $sformatf("%s/c%0d", v.name, i)});
        end
        for (int i = 0; i < v.len; i++) begin
            #1;
            checkOutput();
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        allBits = '1;
        vecs.push_back(mkVec("lw",       6'b100011, 6'b000000, 1'b0, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 3'b000, 1'b0));
        vecs.push_back(mkVec("sw",       6'b101011, 6'b000000, 1'b0, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 3'b000, 1'b0));
        vecs.push_back(mkVec("add",      6'b000000, 6'b100000, 1'b0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b010, 1'b0));
        vecs.push_back(mkVec("sub",      6'b000000, 6'b100010, 1'b0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b110, 1'b0));
        vecs.push_back(mkVec("and",      6'b000000, 6'b100100, 1'b0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b000, 1'b0));
        vecs.push_back(mkVec("or",       6'b000000, 6'b100101, 1'b0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b001, 1'b0));
        vecs.push_back(mkVec("slt",      6'b000000, 6'b101010, 1'b0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b111, 1'b0));
        vecs.push_back(mkVec("bad_fn",   6'b000000, 6'b000111, 1'b0, 3, {4'd0, 4'd0, 4'd6, 4'd1, 4'd0}, 3'b000, 1'b1));
        vecs.push_back(mkVec("addi",     6'b001000, 6'b000000, 1'b0, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}, 3'b000, 1'b0));
        vecs.push_back(mkVec("beq_t",    6'b000100, 6'b000000, 1'b1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 3'b000, 1'b0));
        vecs.push_back(mkVec("beq_nt",   6'b000100, 6'b000000, 1'b0, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 3'b000, 1'b0));
        vecs.push_back(mkVec("j",        6'b000010, 6'b000000, 1'b0, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 3'b000, 1'b0));
        vecs.push_back(mkVec("bad_op",   6'b111111, 6'b000000, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 3'b000, 1'b1));
`ifdef MC_CTRL_JAL_EN
        vecs.push_back(mkVec("jal",      6'b000011, 6'b000000, 1'b0, 3, {4'd0, 4'd0, 4'd12, 4'd1, 4'd0}, 3'b000, 1'b0));
`else
        vecs.push_back(mkVec("jal_ill",  6'b000011, 6'b000000, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 3'b000, 1'b1));
`endif

        rst           = 1'b1;
        bus.op        = 6'b100011;
        bus.funct     = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        expectCycle(resetExp(), allBits, "reset0");
        expectCycle(resetExp(), allBits, "reset1");
        rst = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Fetch stalls while memory is not ready: no PC or IR load.
        bus.op        = 6'b000010;
        bus.mem_ready = 1'b0;
        expectCycle(expectFor(4'd0, 1'b0, 1'b0, 3'b000, 1'b0), allBits, "if_wait0");
        expectCycle(expectFor(4'd0, 1'b0, 1'b0, 3'b000, 1'b0), allBits, "if_wait1");
        bus.mem_ready = 1'b1;
        expectCycle(expectFor(4'd0, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "if_go");
        expectCycle(expectFor(4'd1, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "if_id");
        expectCycle(expectFor(4'd9, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "if_j");

        // Store held in MWR for three not-ready cycles, leaving on the fourth.
        bus.op = 6'b101011;
        expectCycle(expectFor(4'd0, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "swh_if");
        expectCycle(expectFor(4'd1, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "swh_id");
        expectCycle(expectFor(4'd2, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "swh_maddr");
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            expectCycle(expectFor(4'd5, 1'b0, 1'b0, 3'b000, 1'b0), allBits, $sformatf("swh_hold%0d", i));
        bus.mem_ready = 1'b1;
        expectCycle(expectFor(4'd5, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "swh_last");
        expectCycle(expectFor(4'd0, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "swh_back_if");
        expectCycle(expectFor(4'd1, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "swh_next_id");
        expectCycle(expectFor(4'd2, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "swh_next_maddr");
        expectCycle(expectFor(4'd5, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "swh_next_mwr");

        // Reset in the middle of a load's memory read.
        bus.op = 6'b100011;
        expectCycle(expectFor(4'd0, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "rmid_if");
        expectCycle(expectFor(4'd1, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "rmid_id");
        expectCycle(expectFor(4'd2, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "rmid_maddr");
        bus.mem_ready = 1'b0;
        sbQ.push_back('{exp: expectFor(4'd3, 1'b0, 1'b0, 3'b000, 1'b0), mask: allBits, name: "rmid_mrd"});
        #1;
        checkOutput();
        #2;
        rst = 1'b1;
        sbQ.push_back('{exp: resetExp(), mask: allBits, name: "rmid_async"});
        #1;
        checkOutput();
        @(negedge clk);
        expectCycle(resetExp(), allBits, "rmid_hold");
        rst           = 1'b0;
        bus.mem_ready = 1'b1;
        bus.op        = 6'b000010;
        expectCycle(expectFor(4'd0, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "rmid_refetch");
        expectCycle(expectFor(4'd1, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "rmid_id2");
        expectCycle(expectFor(4'd9, 1'b1, 1'b0, 3'b000, 1'b0), allBits, "rmid_j");

        if (sbQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover got %0d exp 0", sbQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
